p2s_sched: RTL and testbench
============================

Name: p2s_sched

Overview:
- Round-robin scheduler that shares one parallel-to-serial shifter (4-bit load/send type) among N_REQ requesters.
- Grants one requester at a time and captures its nibble.
- Drives the shifter's load for one cycle, then send for DW cycles, then holds send low for GAP_CYC cycles before the next grant.
- Sits between client blocks and the p2s shifter instance.

Parameters:
N_REQ, 4, number of requesters (2..2^ID_W)
ID_W, 2, width of owner index
DW, 4, data width per transfer = send cycles per frame
GAP_CYC, 1, idle cycles between frames (0 allowed)

Ports:
clk  in  1  clock, all state on rising edge
n_rst  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request, level
req_data  in  N_REQ*DW  requester i data at [i*DW +: DW]
abort  in  1  synchronous frame cancel
ack  out  N_REQ  one-hot grant pulse, one cycle
p2s_din  out  DW  data to shifter
p2s_load  out  1  shifter load strobe
p2s_send  out  1  shifter shift enable
owner  out  ID_W  index of current grantee
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse after the last send cycle

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; ack, p2s_din, p2s_load, p2s_send, owner, busy, done all 0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, SEND, GAP. All outputs are registered.
- IDLE:
  - At any edge with req!=0, select the first set bit searching cyclically from last+1.
  - On that edge: capture its req_data slice into p2s_din, set owner, set last to the granted index, next state LOAD.
  - With req==0, remain in IDLE; outputs hold 0, except p2s_din and owner, which hold their last values.
- LOAD (exactly 1 cycle): p2s_load=1, ack[owner]=1, busy=1; next state SEND with counter=0.
- SEND:
  - p2s_send=1 for exactly DW consecutive cycles. The counter runs 0..DW-1; width holds DW without overflow.
  - After the DW-th cycle, go to GAP if GAP_CYC>0, else IDLE.
- GAP: p2s_send=0, busy=1 for GAP_CYC cycles, then IDLE.
- done: high for one cycle, the cycle immediately after the final SEND cycle (first GAP cycle, or first IDLE cycle when GAP_CYC=0).
- Latency: request sampled at edge T → load high in cycle T+1 → send high in cycles T+2..T+1+DW.
  - Back-to-back frame period = DW+GAP_CYC+2 cycles (7 at defaults).
- p2s_din and owner are stable from LOAD through the end of GAP; they change only at a grant.
- Requester protocol:
  - Hold req and req_data until ack.
  - Dropping req before grant withdraws the request with no side effect.
  - req still high after ack is a new request, arbitrated normally. It loses to other pending requesters because last now points at it.
- Simultaneous requests: strict cyclic order from last+1; no starvation, worst-case wait is N_REQ-1 frames.
- abort:
  - Sampled in LOAD/SEND/GAP. Next state is IDLE; p2s_load, p2s_send and busy drop the following cycle.
  - done is not pulsed. ack already issued in LOAD stands.
  - abort in IDLE is ignored, and a grant on the same edge still proceeds.
  - abort in LOAD: ack is still high in that LOAD cycle; the transfer is cancelled.
- Reset mid-frame: immediate async return to the reset state; the frame is lost, with no ack or done afterwards. The pointer resets to N_REQ-1.
- req bits at indices ≥ N_REQ do not exist; owner never exceeds N_REQ-1.

Test Plan:
1. Single request: reset, req=4'b0100, req_data[11:8]=4'hA.
   - Grant edge T, then: load=1, ack=4'b0100, owner=2 at T+1.
   - p2s_din=4'hA; send=1 for T+2..T+5; done at T+6; busy low at T+7.
2. Round robin: req=4'b1111 held with distinct data 1,2,3,4.
   - Grants in order 0,1,2,3,0.
   - Each load 7 cycles apart; p2s_din matches owner data each frame.
3. Fairness after grant: last=1, req=4'b0011 held → next grant is 0, then 1; never two consecutive grants to the same index while another req is high.
4. Abort: abort=1 during the 2nd SEND cycle → send=0 and busy=0 the next cycle, no done.
   - A pending req is granted at the following IDLE edge.
5. Async reset mid-SEND: n_rst low between clock edges → all outputs 0 immediately.
   - After release, req=4'b1001 grants index 0 first.
6. GAP_CYC=0 build, req=4'b0001 held → load pulses every 6 cycles; done coincides with the IDLE cycle; withdrawal of req before the grant edge yields no ack.

Source files
------------

// File: rtl/p2s_sched.sv
// Round-robin arbiter sharing one p2s shifter: grant -> load 1 cycle -> send DW cycles -> GAP_CYC idle.
// Latency: grant edge T, load at T+1, send T+2..T+1+DW; requesters wait (hold req) until ack.
module p2s_sched #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int DW      = 4,
   parameter int GAP_CYC = 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*DW-1:0]   req_data,
   input  logic                  abort,
   output logic [N_REQ-1:0]      ack,
   output logic [DW-1:0]         p2s_din,
   output logic                  p2s_load,
   output logic                  p2s_send,
   output logic [ID_W-1:0]       owner,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   localparam int MAXC = (DW > GAP_CYC) ? DW : GAP_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SEND_LAST = CW'(DW - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [ID_W-1:0]   last;
   logic [ID_W-1:0]   sel_idx;
   logic              sel_vld;
   logic [ID_W-1:0]   cand;
   int                pos;
   logic              grant;

   logic [N_REQ-1:0]  ack_nxt;
   logic              load_nxt, send_nxt, busy_nxt, done_nxt;

   // Search downward in distance so the nearest requester after last wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      pos     = 0;
      cand    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         pos  = (int'(last) + k) % N_REQ;
         cand = ID_W'(pos);
         if (req[cand]) begin
            sel_vld = 1'b1;
            sel_idx = cand;
         end
      end
   end

   assign grant = (state == IDLE) && sel_vld;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last     <= ID_W'(N_REQ - 1);
         ack      <= '0;
         p2s_din  <= '0;
         p2s_load <= 1'b0;
         p2s_send <= 1'b0;
         owner    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ack      <= ack_nxt;
         p2s_load <= load_nxt;
         p2s_send <= send_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         if (grant) begin
            p2s_din <= req_data[sel_idx*DW +: DW];
            owner   <= sel_idx;
            last    <= sel_idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (sel_vld) state_nxt = LOAD;
         LOAD: begin
            state_nxt = SEND;
            cnt_nxt   = '0;
         end
         SEND: begin
            if (cnt == SEND_LAST) begin
               state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   // Outputs are decoded from the next state so they appear registered.
   always_comb begin
      ack_nxt  = '0;
      load_nxt = (state_nxt == LOAD);
      send_nxt = (state_nxt == SEND);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state == SEND) && (cnt == SEND_LAST) && !abort;
      if (grant) ack_nxt[sel_idx] = 1'b1;
   end

endmodule

// File: tb/tb_p2s_sched.sv
// Directed bench for p2s_sched: default build plus a GAP_CYC=0 build.
module tb_p2s_sched;

   logic        clk = 1'b0;
   logic        n_rst;
   always #5 clk = ~clk;

   logic [3:0]  req, ack, din, req1, ack1, din1;
   logic [15:0] req_data, req_data1;
   logic        abort, abort1;
   logic        load, send, busy, done, load1, send1, busy1, done1;
   logic [1:0]  owner, owner1;

   int tests = 0;
   int fails = 0;

   p2s_sched #(.N_REQ(4), .ID_W(2), .DW(4), .GAP_CYC(1)) dut (
      .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .abort(abort),
      .ack(ack), .p2s_din(din), .p2s_load(load), .p2s_send(send),
      .owner(owner), .busy(busy), .done(done));

   p2s_sched #(.N_REQ(4), .ID_W(2), .DW(4), .GAP_CYC(0)) dut_g0 (
      .clk(clk), .n_rst(n_rst), .req(req1), .req_data(req_data1), .abort(abort1),
      .ack(ack1), .p2s_din(din1), .p2s_load(load1), .p2s_send(send1),
      .owner(owner1), .busy(busy1), .done(done1));

   task automatic apply_reset();
      n_rst = 1'b0;
      req = '0; req1 = '0; abort = 1'b0; abort1 = 1'b0;
      req_data = '0; req_data1 = '0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy && !load && !busy1 && !load1) break;
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      req = '0; req1 = '0; abort = 1'b0; abort1 = 1'b0;
      req_data = 16'hFFFF; req_data1 = 16'hFFFF;
      #12;
      tests++;
      if ({ack, din, load, send, owner, busy, done} !== 15'd0) begin
         fails++; $display("FAIL reset_outputs: got %h want 0", {ack, din, load, send, owner, busy, done});
      end
      tests++;
      if ({ack1, din1, load1, send1, owner1, busy1, done1} !== 15'd0) begin
         fails++; $display("FAIL reset_outputs_g0: got %h want 0", {ack1, din1, load1, send1, owner1, busy1, done1});
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      @(negedge clk);
      req = 4'b0100; req_data = 16'h0A00;
      @(negedge clk);
      tests++;
      if ({load, send, ack, owner, din} !== {1'b1, 1'b0, 4'b0100, 2'd2, 4'hA}) begin
         fails++; $display("FAIL single_load: got load=%b send=%b ack=%b owner=%0d din=%h want 1 0 0100 2 a",
                           load, send, ack, owner, din);
      end
      req = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if ({load, send, ack, din, busy} !== {1'b0, 1'b1, 4'b0000, 4'hA, 1'b1}) begin
            fails++; $display("FAIL single_send%0d: got load=%b send=%b ack=%b din=%h busy=%b want 0 1 0000 a 1",
                              i, load, send, ack, din, busy);
         end
      end
      @(negedge clk);
      tests++;
      if ({done, send, busy} !== 3'b101) begin
         fails++; $display("FAIL single_done: got done=%b send=%b busy=%b want 1 0 1", done, send, busy);
      end
      @(negedge clk);
      tests++;
      if ({done, busy, din, owner} !== {1'b0, 1'b0, 4'hA, 2'd2}) begin
         fails++; $display("FAIL single_idle: got done=%b busy=%b din=%h owner=%0d want 0 0 a 2", done, busy, din, owner);
      end
   endtask

   task automatic test_round_robin();
      int exp_o[5] = '{0, 1, 2, 3, 0};
      int n = 0;
      int prev = 0;
      apply_reset();
      @(negedge clk);
      req = 4'b1111; req_data = 16'h4321;
      for (int cyc = 1; cyc < 50; cyc++) begin
         @(negedge clk);
         if (load) begin
            tests++;
            if ({owner, din} !== {2'(exp_o[n]), 4'(exp_o[n] + 1)}) begin
               fails++; $display("FAIL rr_grant%0d: got owner=%0d din=%h want %0d %h",
                                 n, owner, din, exp_o[n], exp_o[n] + 1);
            end
            if (n > 0) begin
               tests++;
               if (cyc - prev != 7) begin
                  fails++; $display("FAIL rr_period%0d: got %0d want 7", n, cyc - prev);
               end
            end
            prev = cyc;
            n++;
            if (n == 5) break;
         end
      end
      req = '0;
      tests++;
      if (n != 5) begin
         fails++; $display("FAIL rr_count: got %0d loads want 5", n);
      end
      wait_idle();
   endtask

   task automatic test_fairness();
      int exp_o[3] = '{0, 1, 0};
      int n = 0;
      apply_reset();
      @(negedge clk);
      req = 4'b0010; req_data = 16'h0021;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (load) break;
      end
      tests++;
      if ({load, owner} !== {1'b1, 2'd1}) begin
         fails++; $display("FAIL fair_setup: got load=%b owner=%0d want 1 1", load, owner);
      end
      req = '0;
      wait_idle();
      req = 4'b0011;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (load) begin
            tests++;
            if (owner !== 2'(exp_o[n])) begin
               fails++; $display("FAIL fair_grant%0d: got owner=%0d want %0d", n, owner, exp_o[n]);
            end
            n++;
            if (n == 3) break;
         end
      end
      req = '0;
      tests++;
      if (n != 3) begin
         fails++; $display("FAIL fair_count: got %0d loads want 3", n);
      end
      wait_idle();
   endtask

   task automatic test_abort();
      apply_reset();
      @(negedge clk);
      req = 4'b0001; req_data = 16'h0C07;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (load) break;
      end
      tests++;
      if ({load, owner, din} !== {1'b1, 2'd0, 4'h7}) begin
         fails++; $display("FAIL abort_first: got load=%b owner=%0d din=%h want 1 0 7", load, owner, din);
      end
      req = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (send !== 1'b1) begin
         fails++; $display("FAIL abort_send2: got send=%b want 1", send);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if ({send, busy, done, load} !== 4'b0000) begin
         fails++; $display("FAIL abort_drop: got send=%b busy=%b done=%b load=%b want 0 0 0 0", send, busy, done, load);
      end
      @(negedge clk);
      tests++;
      if ({load, owner, ack, din, done} !== {1'b1, 2'd2, 4'b0100, 4'hC, 1'b0}) begin
         fails++; $display("FAIL abort_regrant: got load=%b owner=%0d ack=%b din=%h done=%b want 1 2 0100 c 0",
                           load, owner, ack, din, done);
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_async_reset();
      apply_reset();
      @(negedge clk);
      req = 4'b0010; req_data = 16'h00D0;
      @(negedge clk);
      tests++;
      if ({load, owner} !== {1'b1, 2'd1}) begin
         fails++; $display("FAIL areset_setup: got load=%b owner=%0d want 1 1", load, owner);
      end
      req = '0;
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      tests++;
      if ({ack, din, load, send, owner, busy, done} !== 15'd0) begin
         fails++; $display("FAIL areset_mid: got %h want 0", {ack, din, load, send, owner, busy, done});
      end
      req = 4'b1001; req_data = 16'h5006;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({load, owner, ack, din} !== {1'b1, 2'd0, 4'b0001, 4'h6}) begin
         fails++; $display("FAIL areset_ptr: got load=%b owner=%0d ack=%b din=%h want 1 0 0001 6", load, owner, ack, din);
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_gap0();
      int n = 0;
      int prev = 0;
      int ndone = 0;
      logic bad = 1'b0;
      apply_reset();
      @(negedge clk);
      req1 = 4'b0001; req_data1 = 16'h0005;
      for (int cyc = 1; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done1) begin
            ndone++;
            tests++;
            if (busy1 !== 1'b0 || cyc - prev != 5) begin
               fails++; $display("FAIL g0_done: got busy=%b offset=%0d want 0 5", busy1, cyc - prev);
            end
         end
         if (load1) begin
            tests++;
            if ({owner1, din1} !== {2'd0, 4'h5}) begin
               fails++; $display("FAIL g0_load: got owner=%0d din=%h want 0 5", owner1, din1);
            end
            if (n > 0) begin
               tests++;
               if (cyc - prev != 6) begin
                  fails++; $display("FAIL g0_period%0d: got %0d want 6", n, cyc - prev);
               end
            end
            prev = cyc;
            n++;
            if (n == 3) break;
         end
      end
      req1 = '0;
      tests++;
      if (n != 3 || ndone != 2) begin
         fails++; $display("FAIL g0_count: got loads=%0d dones=%0d want 3 2", n, ndone);
      end
      wait_idle();
      req1 = 4'b0010;
      #2 req1 = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack1 !== 4'b0000 || load1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad !== 1'b0) begin
         fails++; $display("FAIL g0_withdraw: got activity=%b want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_abort();
      test_async_reset();
      test_gap0();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
